// File: rtl/mem_access_unit.sv
// Load/store bridge between the MEM stage and a synchronous data RAM.
// One request in flight; misaligned accesses return an exception without a RAM access.
module mem_access_unit #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_exc,
  output logic [31:0]       exc_badvaddr,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        fault;
  logic        write_q;
  logic        unsigned_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [1:0]  cnt;
  logic [3:0]  we_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_val;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    fault = 1'b0;
    case (req_size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = req_addr[0];
      2'b10:   fault = |req_addr[1:0];
      default: fault = 1'b1;
    endcase
  end

  // Lane enables and replicated data are computed from the live request so
  // they can be registered on the accepting edge and be valid during ISSUE.
  always_comb begin
    we_calc    = 4'b0000;
    wdata_calc = req_wdata;
    case (req_size)
      2'b00: begin
        we_calc    = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        we_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{req_wdata[15:0]}};
      end
      default: begin
        we_calc    = 4'b1111;
        wdata_calc = req_wdata;
      end
    endcase
    if (!req_write) begin
      we_calc = 4'b0000;
    end
  end

  always_comb begin
    lane_b   = ram_rdata[{off_q, 3'b000} +: 8];
    lane_h   = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_val = ram_rdata;
    case (size_q)
      2'b00:   load_val = {{24{~unsigned_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{~unsigned_q & lane_h[15]}}, lane_h};
      default: load_val = ram_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = fault ? RESP : ISSUE;
      ISSUE:   state_next = write_q ? RESP : WAIT;
      WAIT:    if (cnt == 2'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      cnt          <= 2'd0;
      ram_en       <= 1'b0;
      ram_we       <= 4'b0000;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_exc     <= 1'b0;
      exc_badvaddr <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        size_q     <= req_size;
        off_q      <= req_addr[1:0];
      end
      ram_en <= (state_next == ISSUE);
      ram_we <= (state_next == ISSUE) ? we_calc : 4'b0000;
      if (state_next == ISSUE) begin
        ram_addr  <= req_addr[ADDR_W+1:2];
        ram_wdata <= wdata_calc;
      end
      if (state == ISSUE) begin
        cnt <= 2'(RD_LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - 2'd1;
      end
      // Response fields are zero whenever resp_valid is low.
      resp_valid   <= (state_next == RESP);
      resp_rdata   <= (state == WAIT && state_next == RESP) ? load_val : 32'd0;
      resp_exc     <= (state == IDLE && state_next == RESP);
      exc_badvaddr <= (state == IDLE && state_next == RESP) ? req_addr : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: two instances (RD_LAT=1 and RD_LAT=2)
// share stimulus, each backed by its own read pipeline over one RAM array.
module tb_mem_access_unit;

  logic        clka = 1'b0;
  logic        rst  = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic        o1_req_ready, o1_resp_valid, o1_resp_exc, o1_ram_en;
  logic [31:0] o1_resp_rdata, o1_exc_badvaddr, o1_ram_wdata, ram_rdata1;
  logic [3:0]  o1_ram_we;
  logic [9:0]  o1_ram_addr;
  logic        o2_req_ready, o2_resp_valid, o2_resp_exc, o2_ram_en;
  logic [31:0] o2_resp_rdata, o2_exc_badvaddr, o2_ram_wdata, ram_rdata2;
  logic [3:0]  o2_ram_we;
  logic [9:0]  o2_ram_addr;

  always #5 clka = ~clka;

  mem_access_unit #(.ADDR_W(10), .RD_LAT(1)) u_lat1 (
    .clka(clka), .rst(rst), .req_valid(req_valid), .req_ready(o1_req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(o1_resp_valid),
    .resp_rdata(o1_resp_rdata), .resp_exc(o1_resp_exc), .exc_badvaddr(o1_exc_badvaddr),
    .ram_en(o1_ram_en), .ram_we(o1_ram_we), .ram_addr(o1_ram_addr),
    .ram_wdata(o1_ram_wdata), .ram_rdata(ram_rdata1)
  );

  mem_access_unit #(.ADDR_W(10), .RD_LAT(2)) u_lat2 (
    .clka(clka), .rst(rst), .req_valid(req_valid), .req_ready(o2_req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(o2_resp_valid),
    .resp_rdata(o2_resp_rdata), .resp_exc(o2_resp_exc), .exc_badvaddr(o2_exc_badvaddr),
    .ram_en(o2_ram_en), .ram_we(o2_ram_we), .ram_addr(o2_ram_addr),
    .ram_wdata(o2_ram_wdata), .ram_rdata(ram_rdata2)
  );

  logic [31:0] mem [0:1023];
  logic [31:0] d1, d2a, d2b;
  assign ram_rdata1 = d1;
  assign ram_rdata2 = d2b;

  always @(posedge clka) begin
    if (o1_ram_en) begin
      for (int i = 0; i < 4; i++)
        if (o1_ram_we[i]) mem[o1_ram_addr][8*i +: 8] <= o1_ram_wdata[8*i +: 8];
      d1 <= mem[o1_ram_addr];
    end
    if (o2_ram_en) d2a <= mem[o2_ram_addr];
    d2b <= d2a;
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int          en_cnt = 0, resp1_cnt = 0, resp2_cnt = 0, iss_cyc = 0;
  logic [3:0]  iss_we = 4'd0;
  logic [9:0]  iss_addr = 10'd0;
  logic [31:0] iss_wdata = 32'd0;
  always @(negedge clka) begin
    if (o1_ram_en) begin
      en_cnt    <= en_cnt + 1;
      iss_cyc   <= cyc;
      iss_we    <= o1_ram_we;
      iss_addr  <= o1_ram_addr;
      iss_wdata <= o1_ram_wdata;
    end
    if (o1_resp_valid) resp1_cnt <= resp1_cnt + 1;
    if (o2_resp_valid) resp2_cnt <= resp2_cnt + 1;
  end

  int total = 0, bad = 0;
  int acc, lat1, lat2;
  logic [31:0] r1_data, r1_bad, r2_data;
  logic        r1_exc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    int  n;
    bit  g1, g2;
    n = 0;
    @(negedge clka);
    while (!(o1_req_ready && o2_req_ready) && n < 20) begin
      @(negedge clka);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $error("FAIL ready_timeout: observed=0 expected=1");
    end
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(negedge clka);
    acc = cyc;
    req_valid = 1'b0;
    g1 = 0; g2 = 0; lat1 = -1; lat2 = -1;
    for (int k = 0; k < 12 && !(g1 && g2); k++) begin
      if (o1_resp_valid && !g1) begin
        g1 = 1; lat1 = cyc - acc + 1;
        r1_data = o1_resp_rdata; r1_exc = o1_resp_exc; r1_bad = o1_exc_badvaddr;
      end
      if (o2_resp_valid && !g2) begin
        g2 = 1; lat2 = cyc - acc + 1; r2_data = o2_resp_rdata;
      end
      if (!(g1 && g2)) @(negedge clka);
    end
    if (!g1 || !g2) begin
      total++; bad++;
      $error("FAIL resp_timeout: observed=%0d%0d expected=11", g1, g2);
    end
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] exp);
    access(1'b0, sz, u, a, 32'd0);
    chk({tag, "_data"}, r1_data, exp);
    chk({tag, "_lat"}, lat1, 32'd3);
    chk({tag, "_exc"}, 32'(r1_exc), 32'd0);
  endtask

  task automatic exc_chk(input string tag, input logic w, input logic [1:0] sz,
                         input logic [31:0] a);
    int e0;
    e0 = en_cnt;
    access(w, sz, 1'b0, a, 32'hFFFF_FFFF);
    repeat (2) @(negedge clka);
    chk({tag, "_exc"}, 32'(r1_exc), 32'd1);
    chk({tag, "_bad"}, r1_bad, a);
    chk({tag, "_lat"}, lat1, 32'd1);
    chk({tag, "_data"}, r1_data, 32'd0);
    chk({tag, "_no_en"}, en_cnt - e0, 32'd0);
  endtask

  initial begin
    int b, low, acc2, lat_b;
    logic [31:0] first_data, second_data;

    // Reset state
    repeat (2) @(negedge clka);
    chk("rst_ready", 32'(o1_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(o1_resp_valid), 32'd0);
    chk("rst_ram_en", 32'(o1_ram_en), 32'd0);
    chk("rst_ram_we", 32'(o1_ram_we), 32'd0);
    chk("rst_rdata", o1_resp_rdata, 32'd0);
    rst = 1'b1;

    // Store interrupted in ISSUE: write enables drop asynchronously
    @(negedge clka);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h0; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(negedge clka);
    req_valid = 1'b0;
    chk("st_issue_we", 32'(o1_ram_we), 32'hF);
    #2 rst = 1'b0;
    #1 chk("rst_drop_we", 32'(o1_ram_we), 32'd0);
    chk("rst_drop_en", 32'(o1_ram_en), 32'd0);
    @(negedge clka);
    rst = 1'b1;

    // Load interrupted in WAIT (RD_LAT=2 instance)
    b = resp2_cnt;
    req_write = 1'b0; req_size = 2'b10; req_addr = 32'h4; req_valid = 1'b1;
    @(negedge clka);
    req_valid = 1'b0;
    @(negedge clka);
    #2 rst = 1'b0;
    #1 chk("wait_rst_ready", 32'(o2_req_ready), 32'd1);
    chk("wait_rst_en", 32'(o2_ram_en), 32'd0);
    chk("wait_rst_valid", 32'(o2_resp_valid), 32'd0);
    @(negedge clka);
    rst = 1'b1;
    repeat (5) @(negedge clka);
    chk("wait_rst_no_resp", resp2_cnt - b, 32'd0);

    // Normal operation after reset
    access(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678);
    chk("sw8_lat", lat1, 32'd2);
    chk("sw8_data", r1_data, 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'd0);
    chk("lw8_lat2", lat2, 32'd4);
    chk("lw8_data2", r2_data, 32'h12345678);
    chk("lw8_lat1", lat1, 32'd3);

    // sb 0x13
    access(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AB);
    chk("sb_issue_cyc", iss_cyc - acc, 32'd0);
    chk("sb_addr", 32'(iss_addr), 32'd4);
    chk("sb_we", 32'(iss_we), 32'h8);
    chk("sb_wdata", iss_wdata, 32'hABABABAB);
    chk("sb_lat", lat1, 32'd2);
    chk("sb_rdata", r1_data, 32'd0);

    // sh 0x32
    access(1'b1, 2'b01, 1'b0, 32'h32, 32'h1234CDEF);
    chk("sh_addr", 32'(iss_addr), 32'hC);
    chk("sh_we", 32'(iss_we), 32'hC);
    chk("sh_wdata", iss_wdata, 32'hCDEFCDEF);

    // Load extraction against word 0x80FF7F01 at 0x20
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01);
    load_chk("lb22", 2'b00, 1'b0, 32'h22, 32'hFFFFFFFF);
    load_chk("lbu22", 2'b00, 1'b1, 32'h22, 32'h000000FF);
    load_chk("lh22", 2'b01, 1'b0, 32'h22, 32'hFFFF80FF);
    load_chk("lhu20", 2'b01, 1'b1, 32'h20, 32'h00007F01);
    load_chk("lw20", 2'b10, 1'b0, 32'h20, 32'h80FF7F01);
    load_chk("lb21", 2'b00, 1'b0, 32'h21, 32'h0000007F);
    load_chk("lw_wrap", 2'b10, 1'b0, 32'h1020, 32'h80FF7F01);
    load_chk("lb13", 2'b00, 1'b0, 32'h13, 32'hFFFFFFAB);
    chk("idle_valid", 32'(o1_resp_valid), 32'd0);
    chk("idle_rdata", o1_resp_rdata, 32'd0);

    // Misaligned and reserved-size faults
    exc_chk("lw06", 1'b0, 2'b10, 32'h06);
    exc_chk("sh11", 1'b1, 2'b01, 32'h11);
    exc_chk("sz11", 1'b0, 2'b11, 32'h00);

    // Back-to-back loads with req_valid held
    @(negedge clka);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20;
    req_valid = 1'b1;
    @(negedge clka);
    acc = cyc;
    b = resp1_cnt;
    req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h21;
    low = 0; first_data = 32'd0;
    for (int n = 0; n < 10; n++) begin
      if (o1_resp_valid) first_data = o1_resp_rdata;
      if (o1_req_ready) break;
      low++;
      @(negedge clka);
    end
    chk("b2b_ready_low", low, 32'd3);
    chk("b2b_first_data", first_data, 32'h80FF7F01);
    @(negedge clka);
    acc2 = cyc;
    req_valid = 1'b0;
    chk("b2b_accept_gap", acc2 - acc, 32'd4);
    lat_b = -1; second_data = 32'd0;
    for (int n = 0; n < 10; n++) begin
      if (o1_resp_valid) begin
        lat_b = cyc - acc2 + 1;
        second_data = o1_resp_rdata;
        break;
      end
      @(negedge clka);
    end
    chk("b2b_second_lat", lat_b, 32'd3);
    chk("b2b_second_data", second_data, 32'h0000007F);
    repeat (5) @(negedge clka);
    chk("b2b_pulses", resp1_cnt - b, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the MEM stage of the `mips` core and the synchronous `data_ram`.
- Accepts one load/store request at a time over a valid/ready handshake.
- Generates word address, byte-lane write enables and lane-replicated write data; extracts and sign/zero-extends load data.
- Detects misaligned accesses and returns them as exceptions without touching the RAM; core stalls while `req_ready`=0.

Parameters:
- ADDR_W, 10, word-address width driven to data_ram.
- RD_LAT, 1, data_ram read latency in clka cycles (1..3) after the ISSUE cycle.

Ports:
- clka  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; handshake when req_valid&req_ready.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend load (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data.
- resp_exc  out  1  misaligned/reserved-size exception, valid with resp_valid.
- exc_badvaddr  out  32  faulting byte address, valid with resp_exc.
- ram_en  out  1  data_ram enable.
- ram_we  out  4  byte write enables; lane i = bits [8i+7:8i].
- ram_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2].
- ram_wdata  out  32  lane-replicated store data.
- ram_rdata  in  32  data_ram read data.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except req_ready=1. Internal latches and RD counter cleared. A write in flight is dropped (ram_we forced 0 immediately).
- Alignment fault: size 01 with addr[0]=1; size 10 with addr[1:0]≠0; any addr with size 11.
- IDLE: req_ready=1.
  - Aligned request accepted → latch request → ISSUE.
  - Faulting request accepted → RESP with resp_exc=1 and exc_badvaddr=req_addr. No ram_en at any point.
- ISSUE (1 cycle), all RAM outputs registered and valid this cycle:
  - ram_en=1, ram_addr from latched address.
  - Store ram_we: byte → 1<<addr[1:0]; half → addr[1]?1100:0011; word → 1111.
  - Store ram_wdata: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
  - Load: ram_we=0000.
  - Store → RESP. Load → WAIT with counter = RD_LAT.
- WAIT: ram_en=0. Counter decrements each cycle. In the last WAIT cycle, sample ram_rdata:
  - byte → select lane addr[1:0], extend bit 7 (or zero if req_unsigned).
  - half → lane pair addr[1], extend bit 15 (or zero).
  - word → as-is.
  - Then → RESP.
- RESP (1 cycle): resp_valid=1.
  - resp_rdata = extracted value for loads; 0 for stores and exceptions.
  - resp_exc/exc_badvaddr are 0 unless faulted.
  - → IDLE.
- req_ready=0 in ISSUE, WAIT and RESP. A request held across these states is accepted in the next IDLE cycle; no request is ever lost or duplicated.
- Latency (accept at cycle T):
  - store resp_valid at T+2;
  - load at T+2+RD_LAT;
  - exception at T+1.
- Throughput: one request per (latency+1) cycles.
- ram_en/ram_we are high only in ISSUE; never both asserted outside ISSUE.
- resp_rdata, resp_exc and exc_badvaddr are 0 whenever resp_valid=0.
- Address bits above ADDR_W+1 are ignored (wrap-around within RAM).

Test Plan:
- Reset pulse mid-WAIT of a load (RD_LAT=2) → outputs 0, req_ready=1 immediately, no resp_valid after release; next lw at 0x8 completes normally at T+4.
- sb addr 0x13, wdata 0x000000AB → ISSUE cycle: ram_en=1, ram_addr=4, ram_we=1000, ram_wdata=0xABABABAB; resp_valid at T+2, resp_rdata=0.
- RAM word at addr 0x20 = 0x80FF7F01, RD_LAT=1, each load at T+3:
  - lb 0x22 → 0xFFFFFFFF;
  - lbu 0x22 → 0x000000FF;
  - lh 0x22 → 0xFFFF80FF;
  - lhu 0x20 → 0x00007F01;
  - lw 0x20 → 0x80FF7F01.
- lw at 0x06, then sh at 0x11, then size=11 at 0x0 → each: resp_valid at T+1 with resp_exc=1, exc_badvaddr=0x06/0x11/0x00; ram_en never asserted.
- req_valid held high for two back-to-back loads → req_ready low for 1+RD_LAT+1 cycles; second accepted exactly on return to IDLE; exactly two resp_valid pulses with correct data.
